seq_divider16: RTL and testbench



---
 rtl/seq_divider16.sv | 93 +++++++++
 tb/tb_seq_divider16.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider16.sv
// Unsigned restoring divider: one subtract-and-shift step per clock, start/busy/done handshake.
// Latency: done pulses WIDTH edges after the start-sampling edge; divide-by-zero finishes at the sampling edge.
// Backpressure: start is ignored while busy; a new start is accepted in the done cycle for back-to-back use.
module seq_divider16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] p;      // partial remainder; always < divisor so the top bit is never stored
    logic [WIDTH-1:0] d;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dsr;

    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   t;
    logic             qbit;
    logic [WIDTH-1:0] p_nx;
    logic [WIDTH-1:0] d_nx;

    always_comb begin
        p_sh = {p, d[WIDTH-1]};
        t    = p_sh - {1'b0, dsr};
        qbit = ~t[WIDTH];
        p_nx = qbit ? t[WIDTH-1:0] : p_sh[WIDTH-1:0];
        d_nx = {d[WIDTH-2:0], qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            p           <= '0;
            d           <= '0;
            dsr         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            state       <= S_DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            d     <= dividend;
                            dsr   <= divisor;
                            p     <= '0;
                            count <= '0;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    p     <= p_nx;
                    d     <= d_nx;
                    count <= count + CW'(1);
                    // Last step writes results straight from the step logic so done lands on this edge.
                    if (count == CW'(WIDTH - 1)) begin
                        state       <= S_DONE;
                        quotient    <= d_nx;
                        remainder   <= p_nx;
                        div_by_zero <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
endmodule

// File: tb/tb_seq_divider16.sv
// Bench for seq_divider16: cycle-level arithmetic model compared every cycle, plus directed literal checks.
module tb_seq_divider16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        busy;
    logic        done;

    seq_divider16 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: remaining-cycle counter plus results computed with / and %.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_q = '0, m_r = '0;
    logic        m_z = 1'b0;
    logic [15:0] p_q = '0, p_r = '0, last_a = '0, last_b = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_z = 1'b0;
        end else if (m_left > 0) begin
            m_done = 1'b0;
            m_left--;
            if (m_left == 0) begin
                m_q = p_q; m_r = p_r; m_z = 1'b0; m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                last_a = dividend;
                last_b = divisor;
                if (divisor == 16'd0) begin
                    m_q = 16'hFFFF; m_r = dividend; m_z = 1'b1; m_done = 1'b1;
                end else begin
                    p_q = dividend / divisor;
                    p_r = dividend % divisor;
                    m_left = 16;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy, (m_left > 0));
            chk("done", done, m_done);
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("div_by_zero", div_by_zero, m_z);
            chk("busy_and_done", busy & done, 0);
            if (done && !div_by_zero && last_b != 16'd0) begin
                chk("identity", 32'(quotient) * 32'(last_b) + 32'(remainder), 32'(last_a));
                chk("rem_lt_div", remainder < last_b, 1);
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is seen, n = negedges elapsed.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int n);
        start = 1'b1; dividend = a; divisor = b; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
        end while (!done && n < 40);
        if (!done) chk("done_timeout", done, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        logic [15:0] a, b;

        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(16'd100, 16'd7, n);
        chk("lat_100_7", n, 17);
        chk("q_100_7", quotient, 14);
        chk("r_100_7", remainder, 2);
        chk("z_100_7", div_by_zero, 0);

        do_op(16'hFFFF, 16'd1, n);
        chk("q_ffff_1", quotient, 16'hFFFF);
        chk("r_ffff_1", remainder, 0);
        do_op(16'd3, 16'd10, n);
        chk("q_3_10", quotient, 0);
        chk("r_3_10", remainder, 3);

        do_op(16'd5, 16'd0, n);
        chk("lat_div0", n, 1);
        chk("q_5_0", quotient, 16'hFFFF);
        chk("r_5_0", remainder, 5);
        chk("z_5_0", div_by_zero, 1);
        do_op(16'd20, 16'd6, n);
        chk("q_20_6", quotient, 3);
        chk("r_20_6", remainder, 2);
        chk("z_cleared", div_by_zero, 0);

        // A start pulse mid-run must be ignored.
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 16'd10;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 5) begin start = 1'b1; dividend = 16'd7; divisor = 16'd7; end
            if (i == 6) start = 1'b0;
        end
        chk("done_ignore", done, 1);
        chk("q_1000_10", quotient, 100);
        chk("r_1000_10", remainder, 0);

        // Async reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 16'd10;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("no_done_after_reset", seen, 0);
        do_op(16'd9, 16'd4, n);
        chk("q_9_4", quotient, 2);
        chk("r_9_4", remainder, 1);

        // Back-to-back: second start issued in the done cycle.
        do_op(16'd50, 16'd3, n);
        chk("q_50_3", quotient, 16);
        chk("r_50_3", remainder, 2);
        do_op(16'd60, 16'd7, n);
        chk("lat_b2b", n, 17);
        chk("q_60_7", quotient, 8);
        chk("r_60_7", remainder, 4);

        for (int k = 0; k < 2000; k++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 49) == 0) b = 16'd0;
            else if ($urandom_range(0, 1) == 1) b = 16'($urandom_range(1, 255));
            else b = 16'($urandom_range(1, 65535));
            do_op(a, b, n);
            chk("lat_random", n, (b == 16'd0) ? 1 : 17);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
